// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text console: FSM states, the ASCII
// control codes the console reacts to, and the printable character range.
package vga_text_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character buffer: one write port and one registered read port; a read of the
// cell being written in the same cycle returns the previous contents.
module text_ram #(
    parameter int DEPTH = 2100,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_text_console.sv
// Text-mode console: byte stream in, character/glyph coordinates out for a font ROM.
// Optional blinking underline cursor when VGA_TEXT_CURSOR_BLINK_EN is defined.
module vga_text_console
    import vga_text_pkg::*;
#(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int FONT_W = 9,
    parameter int FONT_H = 16
`ifdef VGA_TEXT_CURSOR_BLINK_EN
    ,parameter int BLINK_CYCLES = 12500000
`endif
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9:0]                h_addr,
    input  logic [9:0]                v_addr,
    output logic [7:0]                pix_char,
    output logic [$clog2(FONT_H)-1:0] pix_grow,
    output logic [$clog2(FONT_W)-1:0] pix_gcol,
    output logic                      pix_valid,
    output logic                      cursor_hit,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int GROW_W = $clog2(FONT_H);
    localparam int GCOL_W = $clog2(FONT_W);
    localparam int DEPTH  = ROWS * COLS;
    localparam int AW     = $clog2(DEPTH);

    // Logical rows are rotated through physical storage so scrolling is O(COLS).
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                  input logic [ROW_W-1:0] lrow);
        logic [ROW_W:0] sum;
        sum = {1'b0, top} + {1'b0, lrow};
        if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                input logic [COL_W-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    state_t            state_reg;
    logic [AW-1:0]     clr_idx_reg;
    logic [COL_W-1:0]  cursor_col_reg;
    logic [ROW_W-1:0]  cursor_row_reg;
    logic [ROW_W-1:0]  top_row_reg;

    logic              accept, is_print, is_lf, is_cr, is_bs, is_ff, at_last_col, advance;
    logic [ROW_W-1:0]  cur_phys, bottom_phys;
    logic              we;
    logic [AW-1:0]     waddr, raddr;
    logic [7:0]        wdata, rdata;

    assign in_ready    = (state_reg == IDLE);
    assign accept      = in_ready && in_valid;
    assign is_print    = is_printable(in_data);
    assign is_lf       = (in_data == ASCII_LF);
    assign is_cr       = (in_data == ASCII_CR);
    assign is_bs       = (in_data == ASCII_BS);
    assign is_ff       = (in_data == ASCII_FF);
    assign at_last_col = (cursor_col_reg == COL_W'(COLS-1));
    assign advance     = accept && ((is_print && at_last_col) || is_lf);
    assign cur_phys    = phys_row(top_row_reg, cursor_row_reg);
    assign bottom_phys = (top_row_reg == '0) ? ROW_W'(ROWS-1) : top_row_reg - 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= CLR_ALL;
            clr_idx_reg    <= '0;
            cursor_col_reg <= '0;
            cursor_row_reg <= '0;
            top_row_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && is_ff) begin
                        state_reg   <= CLR_ALL;
                        clr_idx_reg <= '0;
                    end else if (accept) begin
                        if (is_print && !at_last_col)
                            cursor_col_reg <= cursor_col_reg + 1'b1;
                        else if (is_print || is_lf || is_cr)
                            cursor_col_reg <= '0;
                        else if (is_bs && cursor_col_reg != '0)
                            cursor_col_reg <= cursor_col_reg - 1'b1;
                        // Advancing past the bottom row scrolls and blanks the recycled row.
                        if (advance) begin
                            if (cursor_row_reg != ROW_W'(ROWS-1)) begin
                                cursor_row_reg <= cursor_row_reg + 1'b1;
                            end else begin
                                top_row_reg <= (top_row_reg == ROW_W'(ROWS-1)) ? '0 : top_row_reg + 1'b1;
                                state_reg   <= CLR_ROW;
                                clr_idx_reg <= '0;
                            end
                        end
                    end
                end
                CLR_ROW: begin
                    if (clr_idx_reg == AW'(COLS-1)) state_reg <= IDLE;
                    else clr_idx_reg <= clr_idx_reg + 1'b1;
                end
                CLR_ALL: begin
                    if (clr_idx_reg == AW'(DEPTH-1)) begin
                        state_reg      <= IDLE;
                        cursor_col_reg <= '0;
                        cursor_row_reg <= '0;
                        top_row_reg    <= '0;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + 1'b1;
                    end
                end
                default: state_reg <= CLR_ALL;
            endcase
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = cell_addr(cur_phys, cursor_col_reg);
        wdata = in_data;
        case (state_reg)
            IDLE: begin
                if (accept && is_print) begin
                    we = 1'b1;
                end else if (accept && is_bs && cursor_col_reg != '0) begin
                    we    = 1'b1;
                    waddr = cell_addr(cur_phys, cursor_col_reg - 1'b1);
                    wdata = ASCII_SPACE;
                end
            end
            CLR_ROW: begin
                we    = 1'b1;
                waddr = cell_addr(bottom_phys, '0) + clr_idx_reg;
                wdata = ASCII_SPACE;
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_idx_reg;
                wdata = ASCII_SPACE;
            end
            default: ;
        endcase
    end

    // Pixel side: cell lookup is combinational, everything leaves through registers.
    logic [COL_W-1:0]  h_cell;
    logic [ROW_W-1:0]  v_cell;
    logic [GCOL_W-1:0] h_rem;
    logic [GROW_W-1:0] v_rem;
    logic              in_area, hit_next;
    logic              pix_valid_reg, pix_blank_reg, cursor_hit_reg;
    logic [GROW_W-1:0] pix_grow_reg;
    logic [GCOL_W-1:0] pix_gcol_reg;

    assign h_cell  = COL_W'(h_addr / 10'(FONT_W));
    assign v_cell  = ROW_W'(v_addr / 10'(FONT_H));
    assign h_rem   = GCOL_W'(h_addr % 10'(FONT_W));
    assign v_rem   = GROW_W'(v_addr % 10'(FONT_H));
    assign in_area = (h_addr < 10'(COLS*FONT_W)) && (v_addr < 10'(ROWS*FONT_H));
    assign raddr   = in_area ? cell_addr(phys_row(top_row_reg, v_cell), h_cell) : '0;

    text_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef VGA_TEXT_CURSOR_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_W'(BLINK_CYCLES-1)) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign hit_next = in_area && blink_phase_reg && (h_cell == cursor_col_reg) &&
                      (v_cell == cursor_row_reg) && (v_rem == GROW_W'(FONT_H-1));
`else
    assign hit_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_valid_reg  <= 1'b0;
            pix_blank_reg  <= 1'b0;
            pix_grow_reg   <= '0;
            pix_gcol_reg   <= '0;
            cursor_hit_reg <= 1'b0;
        end else begin
            pix_valid_reg  <= in_area;
            pix_blank_reg  <= !in_area;
            pix_grow_reg   <= v_rem;
            pix_gcol_reg   <= h_rem;
            cursor_hit_reg <= hit_next;
        end
    end

    // Blank flag keeps pix_char at 0 straight out of reset, 0x20 outside the area after.
    assign pix_char   = pix_valid_reg ? rdata : (pix_blank_reg ? ASCII_SPACE : 8'h00);
    assign pix_valid  = pix_valid_reg;
    assign pix_grow   = pix_grow_reg;
    assign pix_gcol   = pix_gcol_reg;
    assign cursor_hit = cursor_hit_reg;
    assign cursor_col = cursor_col_reg;
    assign cursor_row = cursor_row_reg;

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Parametrised text-mode console for the VGA path: a writable character buffer with a cursor, auto-wrap, hardware scroll and a clear command.
- A byte stream (e.g. decoded PS/2 ASCII) enters through a valid/ready handshake.
- The pixel side maps h_addr/v_addr to a character code plus glyph row/column for an external font ROM.
- Sits between ps2_keyboard/ASCII decode and vga_ctrl/font ROM, with a 1-cycle read latency.

Parameters:
- COLS, 70, characters per row
- ROWS, 30, character rows
- FONT_W, 9, glyph width in pixels
- FONT_H, 16, glyph height in pixels
- BLINK_CYCLES, 12500000, half-period of cursor blink (used only with the optional feature)

Ports:
- clk  in  1  pixel/system clock
- resetn  in  1  asynchronous active-low reset
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  console can accept a byte
- h_addr  in  10  pixel column from vga_ctrl
- v_addr  in  10  pixel row from vga_ctrl
- pix_char  out  8  character code at the pixel's cell (registered)
- pix_grow  out  $clog2(FONT_H)  row within glyph (registered)
- pix_gcol  out  $clog2(FONT_W)  column within glyph (registered)
- pix_valid  out  1  pixel inside the COLS*FONT_W by ROWS*FONT_H area (registered)
- cursor_hit  out  1  pixel lies in the cursor cell and the cursor is visible (registered)
- cursor_col  out  $clog2(COLS)  current cursor column
- cursor_row  out  $clog2(ROWS)  current logical cursor row

Behaviour:
- Storage: ROWS*COLS bytes. Physical row = (top_row + logical_row) mod ROWS. Address = phys_row*COLS + col.
- Reset:
  - On reset: cursor (0,0), top_row 0, in_ready 0, and all pix_* and cursor_hit outputs 0.
  - On release, enter CLR_ALL.
- States:
  - IDLE: in_ready=1.
  - CLR_ROW: writes 0x20 across the new bottom physical row, one cell per cycle, COLS cycles.
  - CLR_ALL: writes 0x20 to all cells, ROWS*COLS cycles, then cursor (0,0), top_row 0.
  - in_ready=0 in both clear states; the FSM returns to IDLE after the last cell.
- A byte is accepted when in_valid && in_ready; it is processed in the same cycle.
- Printable (0x20..0x7E):
  - Write the byte at the cursor, then col++.
  - If col was COLS-1: col=0 and advance the row.
- LF 0x0A: col=0, advance the row.
- CR 0x0D: col=0, no write.
- BS 0x08: if col>0, col-- and write 0x20 at the new position; at col 0 it is a no-op (no reverse wrap).
- FF 0x0C: go to CLR_ALL.
- Any other byte is consumed and ignored.
- Advance row:
  - If row<ROWS-1: row++.
  - Else: top_row=(top_row+1) mod ROWS, row stays ROWS-1, go to CLR_ROW for the new bottom row.
- A byte that causes a scroll is accepted; in_ready drops the next cycle for exactly COLS cycles.
- Pixel read:
  - Combinational cell index: col=h_addr/FONT_W, row=v_addr/FONT_H, gcol=h_addr%FONT_W, grow=v_addr%FONT_H.
  - Synchronous RAM read; all pix_* outputs are registered together with 1-cycle latency.
  - Outside the active area: pix_valid=0 and pix_char=0x20.
- Same-cycle read and write to the same cell returns the old data.
- Reads during clear states return the current RAM content.
- Reset mid-clear or mid-write aborts and restarts CLR_ALL after release.

Optional Feature:
- VGA_TEXT_CURSOR_BLINK_EN defined:
  - A free-running counter toggles a blink phase every BLINK_CYCLES.
  - cursor_hit=1 when pix_valid, the cell equals the cursor cell (logical row), grow==FONT_H-1, and phase=1.
  - The counter and phase reset to 0.
- Not defined: cursor_hit is constant 0 and no counter exists.

Decomposition:
- Package vga_text_pkg:
  - state enum {IDLE, CLR_ROW, CLR_ALL}
  - ASCII_LF/CR/BS/FF/SPACE constants
  - printable range bounds
- Sub-module text_ram: simple dual-port memory, one write port and one synchronous read port, parametrised DEPTH and width 8.

Test Plan:
- Reset, then hold in_valid=0 -> in_ready=0 for 2100 cycles then 1; every cell reads 0x20; cursor (0,0).
- Send "AB" -> cursor (2,0); pixel (h=9,v=0) gives pix_char 0x42, pix_gcol 0, pix_grow 0 one cycle later.
- Send 70 'x' -> cursor (0,1); cell (69,0)=0x78. Then BS at col 0 -> cursor unchanged.
- Send 29 LF then 'Z' LF at row 29 -> in_ready low exactly 70 cycles; row 0 shows old row 1 content; row 29 all 0x20; cursor (0,29).
- Send "Q", BS -> cursor (0,0), cell 0x20; then FF -> 2100-cycle clear and cursor (0,0).
- Pixel (630,0) and (0,480) -> pix_valid 0. With the blink feature and BLINK_CYCLES=4: cursor_hit toggles every 4 cycles on row 15 of the cursor cell.
